// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - four-floor elevator car scheduler
// Latches floor requests, picks travel direction, dwells at floors and handles fire recall.
module elevator_scheduler #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] cur_floor,
  input  logic       overload,
  input  logic       firealarm,
  input  logic       person_detected,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic [3:0] pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_DOWN = 3'd2,
    S_DOOR = 3'd3,
    S_FIRE = 3'd4
  } state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DOOR_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_pending;
  logic [7:0] r_cnt;
  logic       r_dir_up;

  logic [3:0] w_here;
  logic [3:0] w_above_mask;
  logic [3:0] w_below_mask;
  logic [3:0] w_merged;
  logic [3:0] w_served;
  logic       w_at_floor;
  logic       w_any_above;
  logic       w_any_below;
  logic       w_hold;

  always_comb begin
    w_here       = '0;
    w_above_mask = '0;
    w_below_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_here[i]       = (2'(i) == cur_floor);
      w_above_mask[i] = (2'(i) > cur_floor);
      w_below_mask[i] = (2'(i) < cur_floor);
    end
  end

  assign w_merged    = r_pending | req;
  assign w_served    = w_merged & ~w_here;
  assign w_at_floor  = |(r_pending & w_here);
  assign w_any_above = |(r_pending & w_above_mask);
  assign w_any_below = |(r_pending & w_below_mask);
  assign w_hold      = person_detected | overload | (|(req & w_here));

  // Motor and door commands depend only on state and position, so reset drops them at once.
  assign move_up   = (r_state == S_UP) && (cur_floor != 2'd3);
  assign move_down = ((r_state == S_DOWN) || (r_state == S_FIRE)) && (cur_floor != 2'd0);
  assign door_open = (r_state == S_DOOR) || ((r_state == S_FIRE) && (cur_floor == 2'd0));
  assign pending   = r_pending;
  assign state     = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cnt     <= '0;
      r_dir_up  <= 1'b1;
    end else if (firealarm) begin
      r_state   <= S_FIRE;
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending <= w_merged;
          if (w_at_floor) begin
            r_state   <= S_DOOR;
            r_pending <= w_served;
            r_cnt     <= DWELL_LOAD;
          end else if (!overload) begin
            if (w_any_above && w_any_below) r_state <= r_dir_up ? S_UP : S_DOWN;
            else if (w_any_above)           r_state <= S_UP;
            else if (w_any_below)           r_state <= S_DOWN;
          end
        end
        S_UP: begin
          r_dir_up  <= 1'b1;
          r_pending <= w_merged;
          if (w_at_floor) begin
            r_state   <= S_DOOR;
            r_pending <= w_served;
            r_cnt     <= DWELL_LOAD;
          end else if (!w_any_above) begin
            r_state <= S_IDLE;
          end
        end
        S_DOWN: begin
          r_dir_up  <= 1'b0;
          r_pending <= w_merged;
          if (w_at_floor) begin
            r_state   <= S_DOOR;
            r_pending <= w_served;
            r_cnt     <= DWELL_LOAD;
          end else if (!w_any_below) begin
            r_state <= S_IDLE;
          end
        end
        S_DOOR: begin
          // A call for the floor being served keeps the door open instead of re-latching.
          r_pending <= w_served;
          if (w_hold)             r_cnt   <= DWELL_LOAD;
          else if (r_cnt == 8'd0) r_state <= S_IDLE;
          else                    r_cnt   <= r_cnt - 8'd1;
        end
        S_FIRE: begin
          r_pending <= '0;
          if (cur_floor == 2'd0) begin
            r_state  <= S_IDLE;
            r_dir_up <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - scenario bench for elevator_scheduler
// Expected pending values are queued when requests are driven and checked after the edge.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] cur_floor;
  logic       overload;
  logic       firealarm;
  logic       person_detected;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic [3:0] pending;
  logic [2:0] state;

  int total;
  int bad;
  logic [3:0] sb_q[$];
  logic [3:0] exp_p;
  int n;

  elevator_scheduler #(.DOOR_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cur_floor(cur_floor), .overload(overload),
    .firealarm(firealarm), .person_detected(person_detected), .move_up(move_up),
    .move_down(move_down), .door_open(door_open), .pending(pending), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_door(output int cnt);
    cnt = 0;
    while (door_open === 1'b1 && cnt < 60) begin
      cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; cur_floor = '0; overload = 1'b0; firealarm = 1'b0; person_detected = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; cur_floor = '0; overload = 1'b0; firealarm = 1'b0; person_detected = 1'b0;
    #1;
    total++;
    if ({state, pending, move_up, move_down, door_open} !== 10'd0) begin
      bad++; $display("FAIL reset_state: got st=%0d p=%b u=%b d=%b o=%b want all 0", state, pending, move_up, move_down, door_open);
    end
    req = 4'b1111;
    tick();
    total++;
    if (pending !== 4'b0000 || state !== 3'd0) begin
      bad++; $display("FAIL reset_hold: got st=%0d p=%b want st=0 p=0000", state, pending);
    end
    req = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_up_to_top();
    do_reset();
    req = 4'b1000; sb_q.push_back(4'b1000);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p || state !== 3'd0) begin
      bad++; $display("FAIL up_latch: got p=%b st=%0d want p=%b st=0", pending, state, exp_p);
    end
    tick();
    total++;
    if (state !== 3'd1 || move_up !== 1'b1) begin
      bad++; $display("FAIL up_start: got st=%0d up=%b want st=1 up=1", state, move_up);
    end
    cur_floor = 2'd1; tick();
    cur_floor = 2'd2; tick();
    cur_floor = 2'd3; tick();
    total++;
    if (state !== 3'd3 || pending !== 4'b0000 || door_open !== 1'b1 || move_up !== 1'b0) begin
      bad++; $display("FAIL up_arrive: got st=%0d p=%b o=%b u=%b want st=3 p=0000 o=1 u=0", state, pending, door_open, move_up);
    end
    count_door(n);
    total++;
    if (n !== 8 || state !== 3'd0) begin
      bad++; $display("FAIL up_dwell: got cycles=%0d st=%0d want 8 st=0", n, state);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    cur_floor = 2'd1;
    req = 4'b1001; sb_q.push_back(4'b1001);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL sweep_latch: got p=%b want %b", pending, exp_p);
    end
    tick();
    total++;
    if (state !== 3'd1) begin
      bad++; $display("FAIL sweep_up_first: got st=%0d want 1", state);
    end
    cur_floor = 2'd2; tick();
    cur_floor = 2'd3; tick();
    total++;
    if (state !== 3'd3 || pending !== 4'b0001) begin
      bad++; $display("FAIL sweep_f3_door: got st=%0d p=%b want st=3 p=0001", state, pending);
    end
    count_door(n);
    tick();
    total++;
    if (state !== 3'd2 || move_down !== 1'b1) begin
      bad++; $display("FAIL sweep_down: got st=%0d dn=%b want st=2 dn=1", state, move_down);
    end
    cur_floor = 2'd2; tick();
    cur_floor = 2'd1; tick();
    cur_floor = 2'd0; tick();
    total++;
    if (state !== 3'd3 || pending !== 4'b0000) begin
      bad++; $display("FAIL sweep_g_door: got st=%0d p=%b want st=3 p=0000", state, pending);
    end
    count_door(n);
    cur_floor = 2'd1;
    req = 4'b1001; sb_q.push_back(4'b1001);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL sweep_relatch: got p=%b want %b", pending, exp_p);
    end
    tick();
    total++;
    if (state !== 3'd2) begin
      bad++; $display("FAIL sweep_dir_down_pref: got st=%0d want 2", state);
    end
  endtask

  task automatic test_door_hold();
    do_reset();
    cur_floor = 2'd2;
    req = 4'b0100; sb_q.push_back(4'b0100);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL hold_latch: got p=%b want %b", pending, exp_p);
    end
    tick();
    person_detected = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (door_open === 1'b1 && move_up === 1'b0 && move_down === 1'b0) n++;
      tick();
    end
    person_detected = 1'b0;
    total++;
    if (n !== 20) begin
      bad++; $display("FAIL hold_person: got open_cycles=%0d want 20", n);
    end
    count_door(n);
    total++;
    if (n !== 8 || state !== 3'd0) begin
      bad++; $display("FAIL hold_tail: got cycles=%0d st=%0d want 8 st=0", n, state);
    end
  endtask

  task automatic test_fire();
    do_reset();
    cur_floor = 2'd2;
    req = 4'b1000; sb_q.push_back(4'b1000);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL fire_latch: got p=%b want %b", pending, exp_p);
    end
    tick();
    firealarm = 1'b1;
    tick();
    total++;
    if (state !== 3'd4 || pending !== 4'b0000 || move_down !== 1'b1 || door_open !== 1'b0) begin
      bad++; $display("FAIL fire_enter: got st=%0d p=%b dn=%b o=%b want st=4 p=0000 dn=1 o=0", state, pending, move_down, door_open);
    end
    req = 4'b0010; person_detected = 1'b1; overload = 1'b1;
    cur_floor = 2'd1;
    tick();
    total++;
    if (pending !== 4'b0000 || move_down !== 1'b1 || state !== 3'd4) begin
      bad++; $display("FAIL fire_ignore: got p=%b dn=%b st=%0d want p=0000 dn=1 st=4", pending, move_down, state);
    end
    cur_floor = 2'd0;
    #1;
    total++;
    if (door_open !== 1'b1 || move_down !== 1'b0) begin
      bad++; $display("FAIL fire_ground: got o=%b dn=%b want o=1 dn=0", door_open, move_down);
    end
    req = '0; person_detected = 1'b0; overload = 1'b0;
    tick();
    firealarm = 1'b0;
    tick();
    total++;
    if ({state, pending, move_up, move_down, door_open} !== 10'd0) begin
      bad++; $display("FAIL fire_exit: got st=%0d p=%b u=%b d=%b o=%b want all 0", state, pending, move_up, move_down, door_open);
    end
  endtask

  task automatic test_overload();
    do_reset();
    overload = 1'b1;
    req = 4'b0100; sb_q.push_back(4'b0100);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL ovl_latch: got p=%b want %b", pending, exp_p);
    end
    tick(); tick();
    total++;
    if (state !== 3'd0 || move_up !== 1'b0) begin
      bad++; $display("FAIL ovl_block: got st=%0d up=%b want st=0 up=0", state, move_up);
    end
    overload = 1'b0;
    tick();
    total++;
    if (state !== 3'd1 || move_up !== 1'b1) begin
      bad++; $display("FAIL ovl_release: got st=%0d up=%b want st=1 up=1", state, move_up);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    overload = 1'b1;
    cur_floor = 2'd0;
    req = 4'b1010; sb_q.push_back(4'b1010);
    tick();
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL b2b_first: got p=%b want %b", pending, exp_p);
    end
    req = 4'b0100; sb_q.push_back(4'b1110);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p || state !== 3'd0) begin
      bad++; $display("FAIL b2b_second: got p=%b st=%0d want p=%b st=0", pending, state, exp_p);
    end
    overload = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cur_floor = 2'd3;
    req = 4'b0001; sb_q.push_back(4'b0001);
    tick();
    req = '0;
    exp_p = sb_q.pop_front();
    total++;
    if (pending !== exp_p) begin
      bad++; $display("FAIL rmid_latch: got p=%b want %b", pending, exp_p);
    end
    tick();
    total++;
    if (move_down !== 1'b1) begin
      bad++; $display("FAIL rmid_moving: got dn=%b want 1", move_down);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (move_down !== 1'b0 || pending !== 4'b0000 || state !== 3'd0) begin
      bad++; $display("FAIL rmid_async: got dn=%b p=%b st=%0d want dn=0 p=0000 st=0", move_down, pending, state);
    end
    #1;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (state !== 3'd0 || pending !== 4'b0000 || move_down !== 1'b0) begin
      bad++; $display("FAIL rmid_restart: got st=%0d p=%b dn=%b want st=0 p=0000 dn=0", state, pending, move_down);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_up_to_top();
    test_sweep();
    test_door_hold();
    test_fire();
    test_overload();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
